// File: rtl/gamepad_poller.sv
// rtl/gamepad_poller.sv - multi-pad SNES-style serial gamepad poller with frame-based capture
module gamepad_poller #(
  parameter int NUM_PADS   = 2,
  parameter int BUTTONS    = 12,
  parameter int CLK_DIV    = 4,
  parameter int POLL_TICKS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [NUM_PADS-1:0]          pad_data,
  output logic                         pad_latch,
  output logic                         pad_clk,
  output logic [NUM_PADS*BUTTONS-1:0]  buttons,
  output logic [NUM_PADS*BUTTONS-1:0]  pressed,
  output logic [NUM_PADS-1:0]          connected,
  output logic                         frame_valid
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W  = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;
  localparam int IDLE_W = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(BUTTONS - 1);
  localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(POLL_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SHIFT_LO,
    SHIFT_HI
  } state_t;

  logic [DIV_W-1:0]           div_cnt;
  logic                       tick;
  logic [NUM_PADS-1:0]        sync_meta;
  logic [NUM_PADS-1:0]        sync_data;

  state_t                     state;
  logic [BIT_W-1:0]           bit_idx;
  logic [IDLE_W-1:0]          idle_cnt;
  logic                       latch_second;
  logic                       publish;
  logic [BUTTONS-1:0]         raw [NUM_PADS];

  logic [NUM_PADS-1:0]        next_conn;
  logic [NUM_PADS*BUTTONS-1:0] next_btn;

  assign tick = (div_cnt == DIV_LAST);

  // Protocol tick generator: one tick every CLK_DIV system clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous pad data lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync_data <= '0;
    end else begin
      sync_meta <= pad_data;
      sync_data <= sync_meta;
    end
  end

  // Decode a finished frame: an all-zero raw word means nothing drove the line
  always_comb begin
    next_conn = '0;
    next_btn  = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      next_conn[p] = |raw[p];
      if (|raw[p]) begin
        next_btn[p*BUTTONS +: BUTTONS] = ~raw[p];
      end
    end
  end

  // Poll sequencer with registered pin strobes, sample capture and frame publish
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bit_idx      <= '0;
      idle_cnt     <= '0;
      latch_second <= 1'b0;
      publish      <= 1'b0;
      pad_latch    <= 1'b0;
      pad_clk      <= 1'b1;
      buttons      <= '0;
      pressed      <= '0;
      connected    <= '0;
      frame_valid  <= 1'b0;
      for (int p = 0; p < NUM_PADS; p++) begin
        raw[p] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      publish     <= 1'b0;

      // Publish one cycle after the last sample so raw holds the final bit
      if (publish) begin
        connected   <= next_conn;
        buttons     <= next_btn;
        pressed     <= next_btn & ~buttons;
        frame_valid <= 1'b1;
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (idle_cnt == '0) begin
              if (en) begin
                state        <= LATCH;
                pad_latch    <= 1'b1;
                latch_second <= 1'b0;
              end
            end else begin
              idle_cnt <= idle_cnt - 1'b1;
            end
          end

          LATCH: begin
            if (!latch_second) begin
              latch_second <= 1'b1;
            end else begin
              state     <= SHIFT_LO;
              pad_latch <= 1'b0;
              pad_clk   <= 1'b0;
              bit_idx   <= '0;
            end
          end

          SHIFT_LO: begin
            for (int p = 0; p < NUM_PADS; p++) begin
              raw[p][bit_idx] <= sync_data[p];
            end
            pad_clk <= 1'b1;
            state   <= SHIFT_HI;
            if (bit_idx == BIT_LAST) begin
              publish <= 1'b1;
            end
          end

          SHIFT_HI: begin
            if (bit_idx == BIT_LAST) begin
              state    <= IDLE;
              idle_cnt <= IDLE_RELOAD;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              pad_clk <= 1'b0;
              state   <= SHIFT_LO;
            end
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gamepad_poller.sv
// tb/tb_gamepad_poller.sv - self-checking bench for gamepad_poller
module tb_gamepad_poller;

  localparam int NP  = 2;
  localparam int NB  = 12;
  localparam int CD  = 4;
  localparam int PT  = 10;
  localparam int FRAME = (2 + 2*NB + PT) * CD;
  localparam int NP2 = 4;
  localparam int NB2 = 16;
  localparam int CD2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en = 1'b0;
  logic en2 = 1'b1;

  logic [NP-1:0]     pad_data;
  logic              pad_latch, pad_clk;
  logic [NP*NB-1:0]  buttons, pressed;
  logic [NP-1:0]     connected;
  logic              frame_valid;

  logic [NP2-1:0]     pad_data2;
  logic               pad_latch2, pad_clk2;
  logic [NP2*NB2-1:0] buttons2, pressed2;
  logic [NP2-1:0]     connected2;
  logic               frame_valid2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_fv = 0;

  gamepad_poller #(.NUM_PADS(NP), .BUTTONS(NB), .CLK_DIV(CD), .POLL_TICKS(PT)) dut (
    .clk(clk), .rst(rst), .en(en), .pad_data(pad_data),
    .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons), .pressed(pressed),
    .connected(connected), .frame_valid(frame_valid)
  );

  gamepad_poller #(.NUM_PADS(NP2), .BUTTONS(NB2), .CLK_DIV(CD2), .POLL_TICKS(PT)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .pad_data(pad_data2),
    .pad_latch(pad_latch2), .pad_clk(pad_clk2), .buttons(buttons2), .pressed(pressed2),
    .connected(connected2), .frame_valid(frame_valid2)
  );

  // cycle number = index of the last rising edge since reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pad model: shift register loaded on latch, advanced on each shift-clock rise
  logic [NB-1:0] pat [NP];
  logic [NP-1:0] plugged = '1;
  logic [NB-1:0] shreg [NP];
  logic [NP-1:0] plug_snap = '0;
  int idx1 = 0;

  always @(posedge pad_latch) begin
    for (int p = 0; p < NP; p++) shreg[p] = ~pat[p];
    plug_snap = plugged;
    idx1 = 0;
  end
  always @(posedge pad_clk) if (pad_latch === 1'b0) idx1 = idx1 + 1;
  always_comb begin
    pad_data = '0;
    for (int p = 0; p < NP; p++)
      if (plug_snap[p] && idx1 < NB) pad_data[p] = shreg[p][idx1];
  end

  logic [NB2-1:0] pat2 [NP2];
  logic [NB2-1:0] shreg2 [NP2];
  int idx2 = 0;

  always @(posedge pad_latch2) begin
    for (int p = 0; p < NP2; p++) shreg2[p] = ~pat2[p];
    idx2 = 0;
  end
  always @(posedge pad_clk2) if (pad_latch2 === 1'b0) idx2 = idx2 + 1;
  always_comb begin
    pad_data2 = '0;
    for (int p = 0; p < NP2; p++)
      if (idx2 < NB2) pad_data2[p] = shreg2[p][idx2];
  end

  // Reference model: what a frame read from the snapshotted pads must report
  logic [NP*NB-1:0] m_prev = '0;

  task automatic model_frame(output logic [NP*NB-1:0] eb, output logic [NP*NB-1:0] ep,
                             output logic [NP-1:0] ec);
    logic [NB-1:0] line_bits;
    eb = '0;
    ec = '0;
    for (int p = 0; p < NP; p++) begin
      line_bits = plug_snap[p] ? shreg[p] : '0;
      ec[p] = (line_bits != '0);
      if (ec[p]) eb[p*NB +: NB] = ~line_bits;
    end
    ep = eb & ~m_prev;
    m_prev = eb;
  endtask

  task automatic wait_fv(input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      @(negedge clk);
      if (frame_valid) at = cyc;
    end
  endtask

  task automatic do_reset(input logic en_val);
    @(negedge clk);
    rst = 1'b1;
    en = en_val;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_prev = '0;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    checks++; if (pad_latch !== 1'b0) begin failures++; $display("FAIL reset_latch got=%b exp=0", pad_latch); end
    checks++; if (pad_clk !== 1'b1) begin failures++; $display("FAIL reset_clk got=%b exp=1", pad_clk); end
    checks++; if (buttons !== '0) begin failures++; $display("FAIL reset_buttons got=%h exp=0", buttons); end
    checks++; if (pressed !== '0) begin failures++; $display("FAIL reset_pressed got=%h exp=0", pressed); end
    checks++; if (connected !== '0) begin failures++; $display("FAIL reset_connected got=%b exp=0", connected); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fv got=%b exp=0", frame_valid); end
  endtask

  task automatic test_first_frame();
    int lat_first, lat_last, fv_at, fv2;
    logic [NP*NB-1:0] eb, ep;
    logic [NP-1:0] ec;
    pat[0] = '0; pat[1] = '0; plugged = 2'b11;
    do_reset(1'b1);
    lat_first = -1; lat_last = -1; fv_at = -1;
    for (int k = 0; k < 300 && fv_at < 0; k++) begin
      @(negedge clk);
      if (pad_latch) begin
        if (lat_first < 0) lat_first = cyc;
        lat_last = cyc;
      end
      if (frame_valid) fv_at = cyc;
    end
    checks++; if (lat_first != 4) begin failures++; $display("FAIL latch_first got=%0d exp=4", lat_first); end
    checks++; if (lat_last != 11) begin failures++; $display("FAIL latch_last got=%0d exp=11", lat_last); end
    checks++; if (fv_at != 105) begin failures++; $display("FAIL fv_first got=%0d exp=105", fv_at); end
    model_frame(eb, ep, ec);
    checks++; if (buttons !== eb) begin failures++; $display("FAIL ff_buttons got=%h exp=%h", buttons, eb); end
    checks++; if (connected !== 2'b11) begin failures++; $display("FAIL ff_connected got=%b exp=11", connected); end
    checks++; if (pressed !== ep) begin failures++; $display("FAIL ff_pressed got=%h exp=%h", pressed, ep); end
    @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL fv_pulse got=%b exp=0", frame_valid); end
    wait_fv(300, fv2);
    checks++; if (fv2 != 249) begin failures++; $display("FAIL fv_second got=%0d exp=249", fv2); end
    model_frame(eb, ep, ec);
    last_fv = fv2;
  endtask

  task automatic test_press_edge();
    int at;
    logic [NP*NB-1:0] eb, ep;
    logic [NP-1:0] ec;
    pat[0] = 12'h008; pat[1] = '0;
    for (int f = 0; f < 2; f++) begin
      wait_fv(300, at);
      checks++; if (at - last_fv != FRAME) begin failures++; $display("FAIL press_period got=%0d exp=%0d", at - last_fv, FRAME); end
      last_fv = at;
      model_frame(eb, ep, ec);
      checks++; if (buttons[3] !== 1'b1) begin failures++; $display("FAIL press_btn3 f%0d got=%b exp=1", f, buttons[3]); end
      checks++; if (pressed[3] !== (f == 0)) begin failures++; $display("FAIL press_edge3 f%0d got=%b exp=%b", f, pressed[3], f == 0); end
      checks++; if (pressed !== ep) begin failures++; $display("FAIL press_vec f%0d got=%h exp=%h", f, pressed, ep); end
    end
  endtask

  task automatic test_unplug();
    int at;
    logic [NP*NB-1:0] eb, ep;
    logic [NP-1:0] ec;
    plugged = 2'b01; pat[1] = 12'h0F0;
    wait_fv(300, at);
    last_fv = at;
    model_frame(eb, ep, ec);
    checks++; if (connected[1] !== 1'b0) begin failures++; $display("FAIL unplug_conn got=%b exp=0", connected[1]); end
    checks++; if (buttons[23:12] !== 12'h000) begin failures++; $display("FAIL unplug_btn got=%h exp=000", buttons[23:12]); end
    checks++; if (pressed[23:12] !== 12'h000) begin failures++; $display("FAIL unplug_prs got=%h exp=000", pressed[23:12]); end
    plugged = 2'b11; pat[1] = 12'h001;
    wait_fv(300, at);
    last_fv = at;
    model_frame(eb, ep, ec);
    checks++; if (pressed[12] !== 1'b1) begin failures++; $display("FAIL replug_prs12 got=%b exp=1", pressed[12]); end
    checks++; if (connected !== ec) begin failures++; $display("FAIL replug_conn got=%b exp=%b", connected, ec); end
    checks++; if (pressed !== ep) begin failures++; $display("FAIL replug_vec got=%h exp=%h", pressed, ep); end
  endtask

  task automatic test_random(input int frames);
    int at;
    logic [NP*NB-1:0] eb, ep;
    logic [NP-1:0] ec;
    for (int f = 0; f < frames; f++) begin
      for (int p = 0; p < NP; p++) begin
        pat[p] = NB'($urandom);
        plugged[p] = ($urandom_range(0, 3) != 0);
      end
      wait_fv(300, at);
      checks++; if (at - last_fv != FRAME) begin failures++; $display("FAIL rnd_period f%0d got=%0d exp=%0d", f, at - last_fv, FRAME); end
      last_fv = at;
      model_frame(eb, ep, ec);
      checks++; if (buttons !== eb) begin failures++; $display("FAIL rnd_buttons f%0d got=%h exp=%h", f, buttons, eb); end
      checks++; if (pressed !== ep) begin failures++; $display("FAIL rnd_pressed f%0d got=%h exp=%h", f, pressed, ep); end
      checks++; if (connected !== ec) begin failures++; $display("FAIL rnd_conn f%0d got=%b exp=%b", f, connected, ec); end
    end
  endtask

  task automatic test_en_drop();
    int at, rises, c, exp_at;
    logic prev_l;
    logic [NP*NB-1:0] eb, ep;
    logic [NP-1:0] ec;
    pat[0] = 12'h421; pat[1] = 12'h810; plugged = 2'b11;
    do_reset(1'b1);
    while (cyc < 50) @(negedge clk);
    en = 1'b0;
    wait_fv(200, at);
    checks++; if (at != 105) begin failures++; $display("FAIL endrop_fv got=%0d exp=105", at); end
    model_frame(eb, ep, ec);
    checks++; if (buttons !== eb) begin failures++; $display("FAIL endrop_btn got=%h exp=%h", buttons, eb); end
    rises = 0; prev_l = pad_latch;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (pad_latch && !prev_l) rises++;
      prev_l = pad_latch;
    end
    checks++; if (rises != 0) begin failures++; $display("FAIL endrop_rises got=%0d exp=0", rises); end
    repeat ($urandom_range(0, 7)) @(negedge clk);
    c = cyc;
    en = 1'b1;
    exp_at = (c / CD + 1) * CD;
    at = -1;
    for (int k = 0; k < 40 && at < 0; k++) begin
      @(negedge clk);
      if (pad_latch) at = cyc;
    end
    checks++; if (at != exp_at) begin failures++; $display("FAIL enrise_latch got=%0d exp=%0d", at, exp_at); end
  endtask

  task automatic test_reset_mid();
    int at;
    logic [NP*NB-1:0] eb, ep;
    logic [NP-1:0] ec;
    pat[0] = 12'h0A5; pat[1] = 12'h3C0; plugged = 2'b11;
    do_reset(1'b1);
    wait_fv(200, at);
    model_frame(eb, ep, ec);
    while (cyc < 180) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pad_clk !== 1'b1) begin failures++; $display("FAIL rmid_clk got=%b exp=1", pad_clk); end
    checks++; if (pad_latch !== 1'b0) begin failures++; $display("FAIL rmid_latch got=%b exp=0", pad_latch); end
    checks++; if (buttons !== '0 || pressed !== '0 || connected !== '0)
      begin failures++; $display("FAIL rmid_outs got=%h/%h/%b exp=0", buttons, pressed, connected); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL rmid_fv got=%b exp=0", frame_valid); end
    @(negedge clk);
    rst = 1'b0;
    m_prev = '0;
    at = -1;
    for (int k = 0; k < 50 && at < 0; k++) begin
      @(negedge clk);
      if (pad_latch) at = cyc;
    end
    checks++; if (at != CD) begin failures++; $display("FAIL rmid_relatch got=%0d exp=%0d", at, CD); end
    wait_fv(200, at);
    checks++; if (at != 105) begin failures++; $display("FAIL rmid_fv_at got=%0d exp=105", at); end
    model_frame(eb, ep, ec);
    checks++; if (pressed !== ep) begin failures++; $display("FAIL rmid_pressed got=%h exp=%h", pressed, ep); end
  endtask

  task automatic test_big();
    int at;
    logic [NP2*NB2-1:0] eb2;
    logic [NP2-1:0] ec2;
    for (int p = 0; p < NP2; p++) pat2[p] = {4'(p), 12'($urandom)};
    do_reset(1'b1);
    at = -1;
    for (int k = 0; k < 400 && at < 0; k++) begin
      @(negedge clk);
      if (frame_valid2) at = cyc;
    end
    checks++; if (at != (2 + 2*NB2) * CD2 + 1) begin failures++; $display("FAIL big_fv got=%0d exp=%0d", at, (2 + 2*NB2) * CD2 + 1); end
    eb2 = '0; ec2 = '0;
    for (int p = 0; p < NP2; p++) begin
      ec2[p] = (pat2[p] != '1);
      if (ec2[p]) eb2[p*NB2 +: NB2] = pat2[p];
    end
    checks++; if (buttons2 !== eb2) begin failures++; $display("FAIL big_buttons got=%h exp=%h", buttons2, eb2); end
    checks++; if (pressed2 !== eb2) begin failures++; $display("FAIL big_pressed got=%h exp=%h", pressed2, eb2); end
    checks++; if (connected2 !== ec2) begin failures++; $display("FAIL big_conn got=%b exp=%b", connected2, ec2); end
  endtask

  initial begin
    pat[0] = '0; pat[1] = '0;
    for (int p = 0; p < NP2; p++) pat2[p] = '0;
    test_reset();
    test_first_frame();
    test_press_edge();
    test_unplug();
    test_random(8);
    test_en_drop();
    test_reset_mid();
    test_big();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
